// File: rtl/motion_seg_sequencer_pkg.sv
// motion_defs: descriptor layout, FSM encoding and flag indices shared by the segment sequencer
package motion_defs;
  localparam int SEG_W = 224;
  localparam int CTRL_LSB = 0;
  localparam int DT_LSB = 32;
  localparam int STEPS_LSB = 64;
  localparam int J0_LSB = 96;
  localparam int J1_LSB = 128;
  localparam int J2_LSB = 160;
  localparam int J3_LSB = 192;
  localparam int FLG_OVF = 0;
  localparam int FLG_ABT = 1;
  localparam int FLG_UND = 2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} seq_state_t;
endpackage

// File: rtl/motion_seg_sequencer_if.sv
// motion_seg_sequencer_if: host push/control and datapath load/status signals of the segment sequencer
interface motion_seg_sequencer_if #(parameter int AW = 4);
  import motion_defs::*;
  logic push_stb;
  logic [SEG_W-1:0] push_desc;
  logic enable;
  logic flush;
  logic clr_flags;
  logic seg_done;
  logic abort;
  logic load_stb;
  logic [31:0] ld_ctrl;
  logic [31:0] ld_dt;
  logic [31:0] ld_steps;
  logic [127:0] ld_j;
  logic dp_abort;
  logic busy;
  logic full;
  logic [AW:0] level;
  logic [15:0] seg_count;
  logic [2:0] flags;
  modport master(
    output push_stb, push_desc, enable, flush, clr_flags, seg_done, abort,
    input load_stb, ld_ctrl, ld_dt, ld_steps, ld_j, dp_abort, busy, full, level, seg_count, flags
  );
  modport slave(
    input push_stb, push_desc, enable, flush, clr_flags, seg_done, abort,
    output load_stb, ld_ctrl, ld_dt, ld_steps, ld_j, dp_abort, busy, full, level, seg_count, flags
  );
endinterface

// File: rtl/motion_seg_fifo.sv
// motion_seg_fifo: synchronous descriptor FIFO; flush drops everything, push while full or flushing is ignored
module motion_seg_fifo
  import motion_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [SEG_W-1:0] push_desc,
  input  logic pop,
  input  logic flush,
  output logic [SEG_W-1:0] head,
  output logic full,
  output logic [AW:0] level
);
  logic [SEG_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign do_push = push && !full && !flush;
  assign do_pop = pop && level != '0 && !flush;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= push_desc;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/motion_seg_sequencer.sv
// motion_seg_sequencer: queues motion segments and issues them back-to-back to the datapath.
// MOTION_SEQ_UNDERRUN_EN enables the sticky underrun flag (flags[2]).
module motion_seg_sequencer
  import motion_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input logic clk,
  input logic rst,
  motion_seg_sequencer_if.slave bus
);
  logic [SEG_W-1:0] head;
  logic full_q;
  logic [AW:0] lvl;
  seq_state_t state, nxt;
  logic pop, q_flush, can_issue, done_cnt;
  logic [2:0] flag_set;
  motion_seg_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk), .rst(rst), .push(bus.push_stb), .push_desc(bus.push_desc),
    .pop(pop), .flush(q_flush), .head(head), .full(full_q), .level(lvl)
  );
  assign can_issue = bus.enable && lvl != '0 && !bus.flush;
  assign q_flush = bus.flush || (state == ST_HALT && bus.seg_done);
  assign done_cnt = bus.seg_done && state != ST_IDLE;
  assign bus.busy = state != ST_IDLE;
  assign bus.full = full_q;
  assign bus.level = lvl;
  // abort outranks a coincident seg_done: the segment still counts but nothing new is issued
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      ST_IDLE: begin
        pop = can_issue;
        nxt = can_issue ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        pop = bus.seg_done && !bus.abort && can_issue;
        nxt = bus.abort ? ST_HALT : !bus.seg_done ? ST_RUN : can_issue ? ST_RUN : ST_IDLE;
      end
      ST_HALT: nxt = bus.seg_done ? ST_IDLE : ST_HALT;
      default: nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    flag_set = '0;
    flag_set[FLG_OVF] = bus.push_stb && full_q && !bus.flush;
    flag_set[FLG_ABT] = state == ST_HALT && bus.seg_done;
`ifdef MOTION_SEQ_UNDERRUN_EN
    flag_set[FLG_UND] = state == ST_RUN && bus.seg_done && bus.enable && lvl == '0;
`else
    flag_set[FLG_UND] = 1'b0;
`endif
  end
  always_ff @(posedge clk) state <= rst ? ST_IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.load_stb <= 1'b0;
      bus.ld_ctrl <= '0;
      bus.ld_dt <= '0;
      bus.ld_steps <= '0;
      bus.ld_j <= '0;
      bus.dp_abort <= 1'b0;
      bus.seg_count <= '0;
      bus.flags <= '0;
    end else begin
      bus.load_stb <= pop;
      if (pop) begin
        bus.ld_ctrl <= head[CTRL_LSB +: 32];
        bus.ld_dt <= head[DT_LSB +: 32];
        bus.ld_steps <= head[STEPS_LSB +: 32];
        bus.ld_j <= {head[J3_LSB +: 32], head[J2_LSB +: 32], head[J1_LSB +: 32], head[J0_LSB +: 32]};
      end
      bus.dp_abort <= nxt == ST_HALT;
      bus.seg_count <= bus.seg_count + 16'(done_cnt);
      bus.flags <= (bus.clr_flags ? 3'b000 : bus.flags) | flag_set;
    end
  end
endmodule
